// File: rtl/data_mem_responder.sv
// data_mem_responder: word memory that answers one load/store request at a time after a fixed latency.
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; a request is accepted when both are high at a clock edge
//   req_wr                1 = write, 0 = read
//   req_addr              byte address; bit 0 and the bits above DEPTH_W are ignored
//   req_wdata             write data
//   rsp_valid             one-cycle response pulse, LATENCY cycles after acceptance
//   rsp_rdata             read data (zero for a write response); holds until the next response
//   busy                  a request is in flight
module data_mem_responder #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH_W = 10,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_nx;
    logic [3:0]         cnt;
    logic               lat_wr;
    logic [DEPTH_W-1:0] lat_idx;
    logic [DATA_W-1:0]  lat_wdata;
    logic [DATA_W-1:0]  mem [2**DEPTH_W];
    logic               accept;
    logic               go_resp;
    logic               eff_wr;
    logic [DEPTH_W-1:0] eff_idx;
    logic [DATA_W-1:0]  eff_wdata;
    logic               unused_addr;

    assign unused_addr = ^{req_addr[ADDR_W-1:DEPTH_W+1], req_addr[0]};

    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign rsp_valid = state == RESP;

    // Gating with rst_n stops a LATENCY==1 write from committing while reset is held.
    assign accept = req_valid && req_ready && rst_n;

    // With LATENCY==1 the access happens on the acceptance edge, before the latches load.
    assign eff_wr    = accept ? req_wr : lat_wr;
    assign eff_idx   = accept ? req_addr[DEPTH_W:1] : lat_idx;
    assign eff_wdata = accept ? req_wdata : lat_wdata;

    assign go_resp  = (accept && LATENCY == 1) || (state == WAIT && cnt == 4'd1);
    assign state_nx = accept ? (LATENCY == 1 ? RESP : WAIT) :
                      state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_wr    <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            rsp_rdata <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                lat_wr    <= req_wr;
                lat_idx   <= req_addr[DEPTH_W:1];
                lat_wdata <= req_wdata;
                cnt       <= 4'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (go_resp) rsp_rdata <= eff_wr ? '0 : mem[eff_idx];
        end
    end

    // Storage is deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (go_resp && eff_wr) mem[eff_idx] <= eff_wdata;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Multi-cycle data-memory responder serving the MEM-stage load/store interface of the pipelined CPU.
- Accepts one read or write request via a valid/ready handshake.
- Holds it for a fixed LATENCY, then returns a one-cycle response pulse carrying read data or a write acknowledge.
- Replaces the single-cycle data memory so the hazard unit can exercise stall-on-busy paths.
- Word-organised storage; byte addresses from the CPU, bit 0 ignored.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, request address width (byte address)
DEPTH_W, 10, log2 of storage depth in words
LATENCY, 4, clock edges from request acceptance to response cycle; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_wr  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  byte address
req_wdata  input  DATA_W  write data
req_ready  output  1  responder can accept a request this cycle
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  DATA_W  read data (valid only with rsp_valid on a read)
busy  output  1  request in flight (state != IDLE)

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock.
- Reset values: state=IDLE, rsp_valid=0, rsp_rdata=0, counter=0, latched request=0. req_ready=1 and busy=0 during and after reset.
- Storage array is not reset; contents persist across reset.
- State machine: IDLE, WAIT, RESP.
- req_ready = (state==IDLE); busy = (state!=IDLE).
- Acceptance: req_valid & req_ready at a rising edge.
  - At that edge latch req_wr, req_wdata, and word index = req_addr[DEPTH_W:1]. Address bits above DEPTH_W are ignored (aliasing); bit 0 is ignored.
- IDLE -> WAIT on acceptance when LATENCY>1; counter loaded with LATENCY-1.
- IDLE -> RESP on acceptance when LATENCY==1.
- WAIT: counter decrements each edge. When counter==1, next state is RESP.
- Entry into RESP (the LATENCY-th edge after acceptance):
  - Write: array[index] <= wdata; rsp_rdata <= 0.
  - Read: rsp_rdata <= array[index].
- RESP: rsp_valid=1 for exactly this one cycle; the next edge goes to IDLE and clears rsp_valid. rsp_rdata holds its value until the next response.
- Throughput: one request per LATENCY+1 cycles. req_ready is never high in RESP.
- req_* changes while busy are ignored. A requester holding req_valid high is accepted on the first IDLE cycle.
- No response queuing or reordering; strictly one outstanding request.
- Read-after-write to the same word returns the new data, because requests are serialised.
- Reset mid-operation (WAIT or RESP): request abandoned.
  - A pending write is not committed if reset asserts before the commit edge.
  - No rsp_valid is produced for the abandoned request.
- LATENCY outside 1..15 is illegal; the bench checks with a parameter assertion.

Test Plan:
1. Reset: hold rst_n=0 with req_valid=1 toggling clk -> req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0x0000, no acceptance. Assert rst_n=0 asynchronously between edges mid-WAIT -> busy drops to 0 immediately.
2. Write then read (LATENCY=4):
   - Write 0xBEEF to 0x0010 accepted at edge 0 -> busy=1 cycles 1-4, rsp_valid=1 only in cycle 4 with rsp_rdata=0x0000, req_ready=1 in cycle 5.
   - Read 0x0010 accepted at edge 5 -> rsp_valid in cycle 9 with rsp_rdata=0xBEEF.
3. Address aliasing (DEPTH_W=10): write 0x1234 to 0x0021 -> read 0x0020 returns 0x1234, and read 0x0820 also returns 0x1234.
4. Held request: req_valid=1 continuously with req_addr/req_wdata changing every cycle -> acceptances only at edges 0, 5, 10. Each response reflects the values present at its acceptance edge.
5. Reset mid-write: preload 0xAAAA at 0x0040. Accept write 0x5555 to 0x0040, pull rst_n low in cycle 2, release -> no rsp_valid for it; a later read of 0x0040 returns 0xAAAA.
6. LATENCY=1 build: read accepted at edge 0 -> rsp_valid in cycle 1, req_ready=1 in cycle 2. Back-to-back requests give one response every 2 cycles.
